// File: rtl/cond_pkg.sv
// Shared definitions for the condition-check / flag-register slice:
// ARM condition encodings, flag bit positions and FlagW group bits.
package cond_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'b0000,
        COND_NE = 4'b0001,
        COND_CS = 4'b0010,
        COND_CC = 4'b0011,
        COND_MI = 4'b0100,
        COND_PL = 4'b0101,
        COND_VS = 4'b0110,
        COND_VC = 4'b0111,
        COND_HI = 4'b1000,
        COND_LS = 4'b1001,
        COND_GE = 4'b1010,
        COND_LT = 4'b1011,
        COND_GT = 4'b1100,
        COND_LE = 4'b1101,
        COND_AL = 4'b1110,
        COND_NV = 4'b1111
    } cond_e;

    // Same bit order as the ALU's ALUFlags output.
    localparam int FLAG_V = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    localparam int FLAGW_NZ = 1;
    localparam int FLAGW_CV = 0;

endpackage

// File: rtl/cond_check.sv
// Combinational evaluation of a 4-bit ARM condition field against the
// held flags; the reserved encoding 1111 never passes.
module cond_check
    import cond_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] Flags,
    output logic       CondEx
);

    logic flag_v;
    logic flag_c;
    logic flag_n;
    logic flag_z;
    logic ge;

    assign flag_v = Flags[FLAG_V];
    assign flag_c = Flags[FLAG_C];
    assign flag_n = Flags[FLAG_N];
    assign flag_z = Flags[FLAG_Z];
    assign ge     = (flag_n == flag_v);

    always_comb begin
        CondEx = 1'b0;
        case (cond_e'(Cond))
            COND_EQ: CondEx = flag_z;
            COND_NE: CondEx = ~flag_z;
            COND_CS: CondEx = flag_c;
            COND_CC: CondEx = ~flag_c;
            COND_MI: CondEx = flag_n;
            COND_PL: CondEx = ~flag_n;
            COND_VS: CondEx = flag_v;
            COND_VC: CondEx = ~flag_v;
            COND_HI: CondEx = flag_c & ~flag_z;
            COND_LS: CondEx = ~flag_c | flag_z;
            COND_GE: CondEx = ge;
            COND_LT: CondEx = ~ge;
            COND_GT: CondEx = ~flag_z & ge;
            COND_LE: CondEx = flag_z | ~ge;
            COND_AL: CondEx = 1'b1;
            default: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Flag register plus registered, condition-gated write/branch controls.
// Define COND_UNIT_CNT_EN to build the saturating executed/skipped counters.
module cond_unit
    import cond_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             Valid,
    input  logic [3:0]       Cond,
    input  logic [3:0]       ALUFlags,
    input  logic [1:0]       FlagW,
    input  logic             PCS,
    input  logic             RegW,
    input  logic             MemW,
    input  logic             NoWrite,
    output logic             ValidOut,
    output logic             CondExOut,
    output logic             PCSrc,
    output logic             RegWrite,
    output logic             MemWrite,
    output logic [3:0]       Flags,
    output logic [CNT_W-1:0] ExecCount,
    output logic [CNT_W-1:0] SkipCount
);

    logic       cond_ex;
    logic       ex;

    logic [3:0] flags_d,     flags_q;
    logic       valid_d,     valid_q;
    logic       cond_ex_d,   cond_ex_q;
    logic       pc_src_d,    pc_src_q;
    logic       reg_write_d, reg_write_q;
    logic       mem_write_d, mem_write_q;

    cond_check u_cond_check (
        .Cond   (Cond),
        .Flags  (flags_q),
        .CondEx (cond_ex)
    );

    assign ex = Valid & cond_ex;

    // Only an executing instruction may touch the flags, group by group.
    always_comb begin
        flags_d = flags_q;
        if (ex && FlagW[FLAGW_NZ]) begin
            flags_d[FLAG_N] = ALUFlags[FLAG_N];
            flags_d[FLAG_Z] = ALUFlags[FLAG_Z];
        end
        if (ex && FlagW[FLAGW_CV]) begin
            flags_d[FLAG_V] = ALUFlags[FLAG_V];
            flags_d[FLAG_C] = ALUFlags[FLAG_C];
        end
        valid_d     = Valid;
        cond_ex_d   = ex;
        pc_src_d    = PCS & ex;
        reg_write_d = RegW & ~NoWrite & ex;
        mem_write_d = MemW & ex;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flags_q     <= 4'b0000;
            valid_q     <= 1'b0;
            cond_ex_q   <= 1'b0;
            pc_src_q    <= 1'b0;
            reg_write_q <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            flags_q     <= flags_d;
            valid_q     <= valid_d;
            cond_ex_q   <= cond_ex_d;
            pc_src_q    <= pc_src_d;
            reg_write_q <= reg_write_d;
            mem_write_q <= mem_write_d;
        end
    end

    assign Flags     = flags_q;
    assign ValidOut  = valid_q;
    assign CondExOut = cond_ex_q;
    assign PCSrc     = pc_src_q;
    assign RegWrite  = reg_write_q;
    assign MemWrite  = mem_write_q;

`ifdef COND_UNIT_CNT_EN
    logic [CNT_W-1:0] exec_cnt_d, exec_cnt_q;
    logic [CNT_W-1:0] skip_cnt_d, skip_cnt_q;

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        exec_cnt_d = exec_cnt_q;
        skip_cnt_d = skip_cnt_q;
        if (ex && (exec_cnt_q != '1)) begin
            exec_cnt_d = exec_cnt_q + CNT_W'(1);
        end
        if (Valid && !cond_ex && (skip_cnt_q != '1)) begin
            skip_cnt_d = skip_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            exec_cnt_q <= '0;
            skip_cnt_q <= '0;
        end else begin
            exec_cnt_q <= exec_cnt_d;
            skip_cnt_q <= skip_cnt_d;
        end
    end

    assign ExecCount = exec_cnt_q;
    assign SkipCount = skip_cnt_q;
`else
    assign ExecCount = '0;
    assign SkipCount = '0;
`endif

endmodule
